// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// pipeline writeback stage and late results (multi-cycle units, late loads).
// Late results wait in a 2-entry in-order FIFO. The pipeline normally has
// priority, and a starvation counter forces a one-cycle drain (pipeline
// stall) when a buffered result keeps losing the port.
//
// Optional feature: define WBARB_FWD_EN to let an accepted late result go
// straight to the write port when the FIFO is empty and the pipeline is not
// writing. The default build, with the macro undefined, always buffers late
// results first.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_vld,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic        i_lu_vld,
  input  logic [4:0]  i_lu_rd,
  input  logic [31:0] i_lu_data,
  output logic        o_lu_rdy,
  input  logic [4:0]  i_chk_rd,
  output logic        o_chk_hit,
  output logic        o_stall,
  output logic        o_rf_wren,
  output logic [4:0]  o_rf_rd,
  output logic [31:0] o_rf_wdata
);

  typedef enum logic [1:0] {IDLE, PEND, DRAIN} state_t;

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  state_t      state;
  logic [4:0]  fifo_rd   [2];
  logic [31:0] fifo_data [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic [3:0]  starve_cnt;

  logic lu_accept;
  logic lu_live;
  logic pipe_win;
  logic fifo_win;
  logic direct_win;
  logic push;
  logic pop;
  logic hit_head;
  logic hit_tail;

  // A full FIFO refuses late results; reset also holds the handshake low.
  assign o_lu_rdy  = i_rst_n & (count != 2'd2);
  assign lu_accept = i_lu_vld & o_lu_rdy;
  assign lu_live   = lu_accept & (i_lu_rd != 5'd0);

  // While stalled the pipeline is frozen, so its request is ignored.
  assign pipe_win  = i_wb_vld & ~o_stall;
  assign fifo_win  = ~pipe_win & (count != 2'd0);

`ifdef WBARB_FWD_EN
  assign direct_win = ~pipe_win & (count == 2'd0) & lu_live;
`else
  assign direct_win = 1'b0;
`endif

  assign push = lu_live & ~direct_win;
  assign pop  = fifo_win;

  // Hazard lookup against every valid buffered entry.
  assign hit_head  = (count != 2'd0) && (fifo_rd[rd_ptr] == i_chk_rd);
  assign hit_tail  = (count == 2'd2) && (fifo_rd[~rd_ptr] == i_chk_rd);
  assign o_chk_hit = (i_chk_rd != 5'd0) & (hit_head | hit_tail);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Write-port mux: pipeline, then FIFO head, then a forwarded late result.
  always_comb begin
    o_rf_wren  = 1'b0;
    o_rf_rd    = 5'd0;
    o_rf_wdata = 32'd0;
    if (pipe_win) begin
      o_rf_rd    = i_wb_rd;
      o_rf_wdata = i_wb_data;
      o_rf_wren  = 1'b1;
    end else if (fifo_win) begin
      o_rf_rd    = fifo_rd[rd_ptr];
      o_rf_wdata = fifo_data[rd_ptr];
      o_rf_wren  = 1'b1;
    end else if (direct_win) begin
      o_rf_rd    = i_lu_rd;
      o_rf_wdata = i_lu_data;
      o_rf_wren  = 1'b1;
    end
    if ((o_rf_rd == 5'd0) || !i_rst_n) begin
      o_rf_wren = 1'b0;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_rd[0]   <= 5'd0;
      fifo_rd[1]   <= 5'd0;
      fifo_data[0] <= 32'd0;
      fifo_data[1] <= 32'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      if (push) begin
        fifo_rd[wr_ptr]   <= i_lu_rd;
        fifo_data[wr_ptr] <= i_lu_data;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
    end
  end

  // Control FSM: tracks pending entries, starvation and the one-cycle drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_stall    <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          o_stall    <= 1'b0;
          starve_cnt <= 4'd0;
          if (push) begin
            state <= PEND;
          end
        end
        PEND: begin
          if (pipe_win) begin
            if (starve_cnt == STARVE_LAST) begin
              state   <= DRAIN;
              o_stall <= 1'b1;
            end else begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else begin
            starve_cnt <= 4'd0;
            if (count_next == 2'd0) begin
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          o_stall    <= 1'b0;
          starve_cnt <= 4'd0;
          state      <= (count_next != 2'd0) ? PEND : IDLE;
        end
        default: begin
          state      <= IDLE;
          o_stall    <= 1'b0;
          starve_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles a pending late result may lose to the pipeline before a forced drain (legal range 1..15).
REQ-002 SHALL have ports (name direction width meaning):
- i_clk in 1: single clock; all state on its rising edge.
- i_rst_n in 1: asynchronous, active-low reset.
- i_wb_vld in 1: pipeline writeback request (RegWrite_W).
- i_wb_rd in 5: pipeline destination register.
- i_wb_data in 32: pipeline writeback data (Result_W).
- i_lu_vld in 1: late-unit (multi-cycle unit or late load return) result valid.
- i_lu_rd in 5: late-unit destination register.
- i_lu_data in 32: late-unit result data.
- o_lu_rdy out 1: arbiter can accept a late result.
- i_chk_rd in 5: register number queried by the hazard unit.
- o_chk_hit out 1: i_chk_rd has a pending buffered write.
- o_stall out 1: freeze request to the pipeline (registered).
- o_rf_wren out 1: register-file write enable.
- o_rf_rd out 5: register-file write address.
- o_rf_wdata out 32: register-file write data.

Function
REQ-003 SHALL contain a 2-entry in-order FIFO of {rd, data} for late results; count 0..2, pointers wrap modulo 2.
REQ-004 SHALL drive o_lu_rdy = (count < 2); no same-cycle pass-through when full.
REQ-005 SHALL treat i_lu_vld & o_lu_rdy as an accepted late result; i_lu_rd = 0 is accepted and discarded (no push, no write).
REQ-006 SHALL grant the write port each cycle, priority descending: (a) pipeline if i_wb_vld & !o_stall; (b) FIFO head if count > 0, popping it; (c) a direct late result per REQ-017.
REQ-007 SHALL force o_rf_wren = 0 whenever the selected rd is 0.
REQ-008 SHALL drive o_rf_wren/o_rf_rd/o_rf_wdata combinationally from the grant (pipeline writes have zero added latency).
REQ-009 SHALL implement FSM IDLE (count = 0), PEND (count > 0, o_stall = 0), DRAIN (o_stall = 1).
REQ-010 SHALL keep a 4-bit starvation counter: +1 each cycle in PEND when the pipeline wins the port; cleared on any pop and in IDLE.
REQ-011 SHALL move PEND -> DRAIN on the edge where the counter equals STARVE_LIMIT-1 and the pipeline wins again.
REQ-012 SHALL, in DRAIN, ignore i_wb_vld, write the FIFO head, and then go to PEND if count remains > 0 after the pop, else IDLE. DRAIN lasts exactly one cycle.
REQ-013 SHALL move IDLE -> PEND when a push occurs with no same-cycle direct write, and PEND -> IDLE when a pop empties the FIFO with no same-cycle push.
REQ-014 SHALL allow a simultaneous push and pop: count unchanged, order preserved.
REQ-015 SHALL drive o_chk_hit = 1 iff i_chk_rd != 0 and it matches the rd of any valid FIFO entry. WAW ordering against the pipeline is the hazard unit's responsibility via o_chk_hit; the arbiter never reorders.

Reset
REQ-016 SHALL, while i_rst_n = 0 (asynchronously): count = 0, pointers = 0, starvation counter = 0, state = IDLE, o_stall = 0, o_lu_rdy = 0, o_rf_wren = 0, o_chk_hit = 0. Reset mid-DRAIN or with a non-empty FIFO discards all pending entries.

Configuration
REQ-017 SHALL, with WBARB_FWD_EN defined, write an accepted late result directly (no push) when count = 0 and the pipeline does not win the port: 0-cycle latency.
REQ-018 SHALL, without WBARB_FWD_EN, push every accepted late result: minimum 1-cycle latency from acceptance to o_rf_wren.

Verification
REQ-019 SHALL cover: i_wb_vld = 1, rd = 3, data = 0x11 with no late traffic -> same-cycle o_rf_wren = 1, o_rf_rd = 3, o_rf_wdata = 0x11.
REQ-020 SHALL cover: a late rd = 7, data = 0xAA with the pipeline idle -> written same cycle with WBARB_FWD_EN, else the next cycle; o_chk_hit for rd 7 = 1 only while buffered.
REQ-021 SHALL cover: two late results accepted while the pipeline writes every cycle -> o_lu_rdy = 0 at count = 2; a third i_lu_vld is held off and not lost.
REQ-022 SHALL cover: STARVE_LIMIT = 4 with continuous i_wb_vld and one buffered entry -> o_stall = 1 for exactly one cycle after 4 pipeline wins; the head is written in that cycle; the held pipeline write occurs the cycle after.
REQ-023 SHALL cover: a late result with rd = 0, and a pipeline write with rd = 0 -> o_rf_wren = 0 for both, and count is unchanged by the late result.
REQ-024 SHALL cover: i_rst_n asserted low in DRAIN with count = 2 -> o_stall = 0, o_rf_wren = 0, o_lu_rdy = 0 immediately; after release, o_lu_rdy = 1 and state = IDLE.
